// File: rtl/reservation_station_pkg.sv
// Shared types and sizes for the reservation station and its neighbours.
package reservation_station_pkg;

    localparam int unsigned RS_LEN    = 8;
    localparam int unsigned ROB_LEN   = 4;   // ROB tag width; tag 0 = value in register file
    localparam int unsigned XLEN      = 32;
    localparam int unsigned REG_IDX_W = 5;

    typedef struct packed {
        logic [XLEN-1:0]      inst;
        logic [XLEN-1:0]      rs1_value;
        logic [XLEN-1:0]      rs2_value;
        logic [REG_IDX_W-1:0] dest_reg_idx;
        logic                 valid;
    } id_packet_t;

    typedef struct packed {
        logic [ROB_LEN-1:0] rs1_tag;
        logic [ROB_LEN-1:0] rs2_tag;
        logic               rs1_ready;
        logic               rs2_ready;
    } mt2rs_packet_t;

    typedef struct packed {
        logic [ROB_LEN-1:0] rob_entry;
        logic [XLEN-1:0]    rs1_value;
        logic [XLEN-1:0]    rs2_value;
    } rob2rs_packet_t;

    typedef struct packed {
        logic [ROB_LEN-1:0] reg_tag;
        logic [XLEN-1:0]    reg_value;
    } cdb_packet_t;

    typedef struct packed {
        logic [ROB_LEN-1:0] rob_entry;
    } rs2rob_packet_t;

    typedef struct packed {
        logic [REG_IDX_W-1:0] dest_reg_idx;
        logic [ROB_LEN-1:0]   dest_reg_tag;
    } rs2mt_packet_t;

    typedef struct packed {
        logic [XLEN-1:0]      inst;
        logic [XLEN-1:0]      rs1_value;
        logic [XLEN-1:0]      rs2_value;
        logic [ROB_LEN-1:0]   rob_entry;
        logic [REG_IDX_W-1:0] dest_reg_idx;
        logic                 valid;
    } is_packet_t;

    typedef struct packed {
        logic [ROB_LEN-1:0] tag;
        logic               ready;
        logic [XLEN-1:0]    value;
    } operand_t;

    // Isolate the lowest set bit; zero in gives zero out.
    function automatic logic [RS_LEN-1:0] lowest_one(input logic [RS_LEN-1:0] req);
        return req & (~req + {{(RS_LEN-1){1'b0}}, 1'b1});
    endfunction

    // Resolve one source operand at dispatch, forwarding a same-cycle CDB broadcast.
    function automatic operand_t capture_operand(input logic [ROB_LEN-1:0] tag,
                                                 input logic               mt_ready,
                                                 input logic [XLEN-1:0]    id_value,
                                                 input logic [XLEN-1:0]    rob_value,
                                                 input cdb_packet_t        cdb);
        operand_t op;
        op.tag = tag;
        if (tag == '0) begin
            op.ready = 1'b1;
            op.value = id_value;
        end else if (mt_ready) begin
            op.ready = 1'b1;
            op.value = rob_value;
        end else if (cdb.reg_tag == tag) begin
            op.ready = 1'b1;
            op.value = cdb.reg_value;
        end else begin
            op.ready = 1'b0;
            op.value = '0;
        end
        return op;
    endfunction

endpackage

// File: rtl/reservation_station_entry.sv
// One reservation station slot: holds an instruction until its operands arrive
// and it is explicitly freed by execution.
import reservation_station_pkg::*;

module rs_entry (
    input  logic           clock,
    input  logic           reset,
    input  logic           enable,
    input  logic           clear,
    input  id_packet_t     id_packet_in,
    input  mt2rs_packet_t  mt2rs_packet_in,
    input  rob2rs_packet_t rob2rs_packet_in,
    input  cdb_packet_t    cdb_packet_in,
    output logic           busy,
    output logic           ready,
    output is_packet_t     entry_packet
);

    logic                 busy_q;
    logic [XLEN-1:0]      inst_q;
    logic [REG_IDX_W-1:0] dest_q;
    logic [ROB_LEN-1:0]   rob_q;
    operand_t             op1_q, op2_q;
    operand_t             op1_new, op2_new;
    logic                 cdb_live;

    assign cdb_live = (cdb_packet_in.reg_tag != '0);

    // Operand values as they would be captured if this entry allocates now.
    always_comb begin
        op1_new = capture_operand(mt2rs_packet_in.rs1_tag, mt2rs_packet_in.rs1_ready,
                                  id_packet_in.rs1_value, rob2rs_packet_in.rs1_value,
                                  cdb_packet_in);
        op2_new = capture_operand(mt2rs_packet_in.rs2_tag, mt2rs_packet_in.rs2_ready,
                                  id_packet_in.rs2_value, rob2rs_packet_in.rs2_value,
                                  cdb_packet_in);
    end

    // Entry state: clear beats allocation, allocation beats CDB wakeup.
    always_ff @(posedge clock) begin
        if (reset) begin
            busy_q <= 1'b0;
            inst_q <= '0;
            dest_q <= '0;
            rob_q  <= '0;
            op1_q  <= '0;
            op2_q  <= '0;
        end else if (clear) begin
            busy_q      <= 1'b0;
            op1_q.ready <= 1'b0;
            op2_q.ready <= 1'b0;
        end else if (enable) begin
            busy_q <= 1'b1;
            inst_q <= id_packet_in.inst;
            dest_q <= id_packet_in.dest_reg_idx;
            rob_q  <= rob2rs_packet_in.rob_entry;
            op1_q  <= op1_new;
            op2_q  <= op2_new;
        end else if (busy_q && cdb_live) begin
            if (!op1_q.ready && op1_q.tag == cdb_packet_in.reg_tag) begin
                op1_q.ready <= 1'b1;
                op1_q.value <= cdb_packet_in.reg_value;
            end
            if (!op2_q.ready && op2_q.tag == cdb_packet_in.reg_tag) begin
                op2_q.ready <= 1'b1;
                op2_q.value <= cdb_packet_in.reg_value;
            end
        end
    end

    // Present the held instruction; valid marks it as issuable.
    always_comb begin
        busy                      = busy_q;
        ready                     = busy_q & op1_q.ready & op2_q.ready;
        entry_packet.inst         = inst_q;
        entry_packet.rs1_value    = op1_q.value;
        entry_packet.rs2_value    = op2_q.value;
        entry_packet.rob_entry    = rob_q;
        entry_packet.dest_reg_idx = dest_q;
        entry_packet.valid        = ready;
    end

endmodule

// File: rtl/reservation_station.sv
// Unified reservation station: allocates one entry per cycle from dispatch,
// wakes operands off the CDB and offers the lowest ready entry for issue.
import reservation_station_pkg::*;

module reservation_station (
    input  logic              clock,
    input  logic              reset,
    input  id_packet_t        id_packet_in,
    input  mt2rs_packet_t     mt2rs_packet_in,
    input  rob2rs_packet_t    rob2rs_packet_in,
    input  cdb_packet_t       cdb_packet_in,
    input  logic [RS_LEN-1:0] rs_entry_clear_in,
    output rs2rob_packet_t    rs2rob_packet_out,
    output rs2mt_packet_t     rs2mt_packet_out,
    output is_packet_t        is_packet_out,
    output logic [RS_LEN-1:0] rs_entry_clear_out,
    output logic              valid
);

    logic [RS_LEN-1:0] rs_entry_busy;
    logic [RS_LEN-1:0] rs_entry_ready;
    logic [RS_LEN-1:0] rs_entry_enable;
    logic [RS_LEN-1:0] issue_sel;
    is_packet_t        entry_packets [RS_LEN];
    logic [XLEN-1:0]   last_inst_q;

    // Lowest free entry takes the dispatched instruction.
    always_comb begin
        rs_entry_enable = id_packet_in.valid ? lowest_one(~rs_entry_busy) : '0;
    end

    for (genvar i = 0; i < RS_LEN; i++) begin : g_entry
        rs_entry u_entry (
            .clock           (clock),
            .reset           (reset),
            .enable          (rs_entry_enable[i]),
            .clear           (rs_entry_clear_in[i]),
            .id_packet_in    (id_packet_in),
            .mt2rs_packet_in (mt2rs_packet_in),
            .rob2rs_packet_in(rob2rs_packet_in),
            .cdb_packet_in   (cdb_packet_in),
            .busy            (rs_entry_busy[i]),
            .ready           (rs_entry_ready[i]),
            .entry_packet    (entry_packets[i])
        );
    end

    // Remember the last allocation for the map table and the idle issue packet.
    always_ff @(posedge clock) begin
        if (reset) begin
            rs2mt_packet_out <= '0;
            last_inst_q      <= '0;
        end else if (|rs_entry_enable) begin
            rs2mt_packet_out.dest_reg_idx <= id_packet_in.dest_reg_idx;
            rs2mt_packet_out.dest_reg_tag <= rob2rs_packet_in.rob_entry;
            last_inst_q                   <= id_packet_in.inst;
        end
    end

    // Issue the lowest-index ready entry; otherwise show the last allocated inst, invalid.
    always_comb begin
        issue_sel          = lowest_one(rs_entry_ready);
        rs_entry_clear_out = issue_sel;
        is_packet_out      = '0;
        is_packet_out.inst = last_inst_q;
        rs2rob_packet_out  = '0;
        for (int i = 0; i < RS_LEN; i++) begin
            if (issue_sel[i]) begin
                is_packet_out               = entry_packets[i];
                rs2rob_packet_out.rob_entry = entry_packets[i].rob_entry;
            end
        end
        valid = |(~rs_entry_busy);
    end

endmodule

// File: tb/tb_reservation_station.sv
// Directed bench for reservation_station with an issue scoreboard.
import reservation_station_pkg::*;

module tb_reservation_station;

    logic              clock = 1'b0;
    logic              reset;
    id_packet_t        id_packet_in;
    mt2rs_packet_t     mt2rs_packet_in;
    rob2rs_packet_t    rob2rs_packet_in;
    cdb_packet_t       cdb_packet_in;
    logic [RS_LEN-1:0] rs_entry_clear_in;
    rs2rob_packet_t    rs2rob_packet_out;
    rs2mt_packet_t     rs2mt_packet_out;
    is_packet_t        is_packet_out;
    logic [RS_LEN-1:0] rs_entry_clear_out;
    logic              valid;

    int compared   = 0;
    int mismatched = 0;
    is_packet_t exp_q[$];

    always #5 clock = ~clock;

    reservation_station dut (
        .clock             (clock),
        .reset             (reset),
        .id_packet_in      (id_packet_in),
        .mt2rs_packet_in   (mt2rs_packet_in),
        .rob2rs_packet_in  (rob2rs_packet_in),
        .cdb_packet_in     (cdb_packet_in),
        .rs_entry_clear_in (rs_entry_clear_in),
        .rs2rob_packet_out (rs2rob_packet_out),
        .rs2mt_packet_out  (rs2mt_packet_out),
        .is_packet_out     (is_packet_out),
        .rs_entry_clear_out(rs_entry_clear_out),
        .valid             (valid)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic is_packet_t mk(input logic [31:0] inst, input logic [31:0] v1,
                                      input logic [31:0] v2, input logic [3:0] robe,
                                      input logic [4:0] dest);
        is_packet_t p;
        p.inst = inst; p.rs1_value = v1; p.rs2_value = v2;
        p.rob_entry = robe; p.dest_reg_idx = dest; p.valid = 1'b1;
        return p;
    endfunction

    // Pop the oldest expected issue and compare it with what the DUT is issuing now.
    task automatic check_issue(input string tag, input logic [7:0] onehot);
        is_packet_t e;
        if (exp_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 64'(1), 64'(0));
            return;
        end
        e = exp_q.pop_front();
        chk({tag, "_valid"}, 64'(is_packet_out.valid), 64'(1));
        chk({tag, "_inst"},  64'(is_packet_out.inst), 64'(e.inst));
        chk({tag, "_rs1"},   64'(is_packet_out.rs1_value), 64'(e.rs1_value));
        chk({tag, "_rs2"},   64'(is_packet_out.rs2_value), 64'(e.rs2_value));
        chk({tag, "_rob"},   64'(is_packet_out.rob_entry), 64'(e.rob_entry));
        chk({tag, "_dest"},  64'(is_packet_out.dest_reg_idx), 64'(e.dest_reg_idx));
        chk({tag, "_rs2rob"}, 64'(rs2rob_packet_out.rob_entry), 64'(e.rob_entry));
        chk({tag, "_oh"},    64'(rs_entry_clear_out), 64'(onehot));
    endtask

    task automatic idle();
        id_packet_in      = '0;
        mt2rs_packet_in   = '0;
        rob2rs_packet_in  = '0;
        cdb_packet_in     = '0;
        rs_entry_clear_in = '0;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic dispatch(input logic [31:0] inst, input logic [31:0] v1, input logic [31:0] v2,
                            input logic [4:0] dest, input logic [3:0] t1, input logic [3:0] t2,
                            input logic r1, input logic r2, input logic [3:0] robe,
                            input logic [31:0] rv1, input logic [31:0] rv2);
        id_packet_in.inst         = inst;
        id_packet_in.rs1_value    = v1;
        id_packet_in.rs2_value    = v2;
        id_packet_in.dest_reg_idx = dest;
        id_packet_in.valid        = 1'b1;
        mt2rs_packet_in.rs1_tag   = t1;
        mt2rs_packet_in.rs2_tag   = t2;
        mt2rs_packet_in.rs1_ready = r1;
        mt2rs_packet_in.rs2_ready = r2;
        rob2rs_packet_in.rob_entry = robe;
        rob2rs_packet_in.rs1_value = rv1;
        rob2rs_packet_in.rs2_value = rv2;
    endtask

    initial begin
        idle();
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        #1;

        // Reset state
        chk("rst_valid", 64'(valid), 64'(1));
        chk("rst_is", 64'(is_packet_out), 64'(0));
        chk("rst_oh", 64'(rs_entry_clear_out), 64'(0));
        chk("rst_rs2mt", 64'(rs2mt_packet_out), 64'(0));
        chk("rst_rs2rob", 64'(rs2rob_packet_out), 64'(0));
        chk("rst_busy", 64'(dut.rs_entry_busy), 64'(0));

        // 1: tags 0/0, values from decode
        dispatch(32'hABCDEF12, 32'd5, 32'd6, 5'd3, 4'd0, 4'd0, 1'b0, 1'b0, 4'd1, 32'hEE, 32'hFF);
        exp_q.push_back(mk(32'hABCDEF12, 32'd5, 32'd6, 4'd1, 5'd3));
        #1;
        chk("t1_enable", 64'(dut.rs_entry_enable), 64'(8'b1));
        tick(); idle(); #1;
        chk("t1_busy", 64'(dut.rs_entry_busy), 64'(8'b1));
        chk("t1_ready", 64'(dut.rs_entry_ready), 64'(8'b1));
        chk("t1_tag", 64'(rs2mt_packet_out.dest_reg_tag), 64'(1));
        chk("t1_didx", 64'(rs2mt_packet_out.dest_reg_idx), 64'(3));
        check_issue("t1", 8'b1);

        // 2: tags 1/1 ready in ROB; entry 0 still busy so entry 1 allocates
        dispatch(32'h11, 32'd7, 32'd8, 5'd4, 4'd1, 4'd1, 1'b1, 1'b1, 4'd2, 32'h20, 32'h21);
        exp_q.push_back(mk(32'h11, 32'h20, 32'h21, 4'd2, 5'd4));
        #1;
        chk("t2_enable", 64'(dut.rs_entry_enable), 64'(8'b10));
        tick(); idle(); #1;
        chk("t2_busy", 64'(dut.rs_entry_busy), 64'(8'b11));
        chk("t2_tag", 64'(rs2mt_packet_out.dest_reg_tag), 64'(2));
        chk("t2_still0", 64'(rs_entry_clear_out), 64'(8'b1));
        rs_entry_clear_in = 8'b1;
        tick(); idle(); #1;
        check_issue("t2", 8'b10);
        rs_entry_clear_in = 8'b10;
        tick(); idle(); #1;
        chk("t2_freed", 64'(dut.rs_entry_busy), 64'(0));
        chk("t2_idle_valid", 64'(is_packet_out.valid), 64'(0));
        chk("t2_idle_inst", 64'(is_packet_out.inst), 64'(32'h11));

        // 3: both waiting on tag 1
        dispatch(32'h33, 32'd0, 32'd0, 5'd5, 4'd1, 4'd1, 1'b0, 1'b0, 4'd4, 32'h0, 32'h0);
        exp_q.push_back(mk(32'h33, 32'd1, 32'd1, 4'd4, 5'd5));
        tick(); idle(); #1;
        chk("t3_notready", 64'(dut.rs_entry_ready), 64'(0));
        chk("t3_idle_inst", 64'(is_packet_out.inst), 64'(32'h33));
        chk("t3_tag", 64'(rs2mt_packet_out.dest_reg_tag), 64'(4));
        tick(); tick();
        chk("t3_hold", 64'(dut.rs_entry_ready), 64'(0));
        cdb_packet_in = '{reg_tag: 4'd1, reg_value: 32'd1};
        tick(); idle(); #1;
        check_issue("t3", 8'b1);
        rs_entry_clear_in = 8'b1;
        tick(); idle(); #1;
        chk("t3_freed", 64'(dut.rs_entry_busy), 64'(0));

        // 4: distinct tags 3/4
        dispatch(32'h44, 32'd0, 32'd0, 5'd6, 4'd3, 4'd4, 1'b0, 1'b0, 4'd5, 32'h0, 32'h0);
        exp_q.push_back(mk(32'h44, 32'd10, 32'd10, 4'd5, 5'd6));
        tick(); idle();
        cdb_packet_in = '{reg_tag: 4'd4, reg_value: 32'd10};
        tick(); idle(); #1;
        chk("t4_half", 64'(dut.rs_entry_ready), 64'(0));
        cdb_packet_in = '{reg_tag: 4'd3, reg_value: 32'd10};
        tick(); idle(); #1;
        check_issue("t4", 8'b1);
        rs_entry_clear_in = 8'b1;
        tick(); idle();

        // 5: rs1 waits on tag 2, rs2 from decode
        dispatch(32'h55, 32'd0, 32'h55, 5'd7, 4'd2, 4'd0, 1'b0, 1'b0, 4'd6, 32'h0, 32'h0);
        exp_q.push_back(mk(32'h55, 32'd10, 32'h55, 4'd6, 5'd7));
        tick(); idle(); #1;
        chk("t5_wait", 64'(dut.rs_entry_ready), 64'(0));
        cdb_packet_in = '{reg_tag: 4'd2, reg_value: 32'd10};
        tick(); idle(); #1;
        check_issue("t5", 8'b1);
        rs_entry_clear_in = 8'b1;
        tick(); idle(); #1;
        chk("t5_freed", 64'(dut.rs_entry_busy), 64'(0));

        // CDB broadcast in the dispatch cycle is forwarded
        dispatch(32'h66, 32'd0, 32'd3, 5'd1, 4'd7, 4'd0, 1'b0, 1'b0, 4'd7, 32'h0, 32'h0);
        cdb_packet_in = '{reg_tag: 4'd7, reg_value: 32'h77};
        exp_q.push_back(mk(32'h66, 32'h77, 32'd3, 4'd7, 5'd1));
        tick(); idle(); #1;
        check_issue("fwd", 8'b1);
        rs_entry_clear_in = 8'b1;
        tick(); idle();

        // Clear wins over a CDB hit on the same entry
        dispatch(32'h88, 32'd0, 32'd0, 5'd2, 4'd8, 4'd8, 1'b0, 1'b0, 4'd9, 32'h0, 32'h0);
        tick(); idle();
        rs_entry_clear_in = 8'b1;
        cdb_packet_in = '{reg_tag: 4'd8, reg_value: 32'd5};
        tick(); idle(); #1;
        chk("clrpri_busy", 64'(dut.rs_entry_busy), 64'(0));
        chk("clrpri_ready", 64'(dut.rs_entry_ready), 64'(0));

        // 6: fill every entry
        for (int i = 0; i < 8; i++) begin
            dispatch(32'h100 + 32'(i), 32'(i), 32'(i + 1), 5'(i), 4'd0, 4'd0, 1'b0, 1'b0,
                     4'(i + 1), 32'h0, 32'h0);
            tick(); idle();
        end
        exp_q.push_back(mk(32'h100, 32'd0, 32'd1, 4'd1, 5'd0));
        #1;
        chk("full_valid", 64'(valid), 64'(0));
        chk("full_busy", 64'(dut.rs_entry_busy), 64'(8'hFF));
        check_issue("full", 8'b1);
        dispatch(32'h999, 32'd0, 32'd0, 5'd9, 4'd0, 4'd0, 1'b0, 1'b0, 4'd12, 32'h0, 32'h0);
        #1;
        chk("full_enable", 64'(dut.rs_entry_enable), 64'(0));
        tick(); idle(); #1;
        chk("drop_busy", 64'(dut.rs_entry_busy), 64'(8'hFF));
        chk("drop_tag", 64'(rs2mt_packet_out.dest_reg_tag), 64'(8));
        rs_entry_clear_in = 8'b1000;
        tick(); idle(); #1;
        chk("onefree_valid", 64'(valid), 64'(1));
        chk("onefree_busy", 64'(dut.rs_entry_busy), 64'(8'hF7));
        dispatch(32'hAAA, 32'd0, 32'd0, 5'd10, 4'd0, 4'd0, 1'b0, 1'b0, 4'd9, 32'h0, 32'h0);
        #1;
        chk("realloc_en", 64'(dut.rs_entry_enable), 64'(8'b1000));
        tick(); idle(); #1;
        chk("realloc_busy", 64'(dut.rs_entry_busy), 64'(8'hFF));
        chk("realloc_tag", 64'(rs2mt_packet_out.dest_reg_tag), 64'(9));
        rs_entry_clear_in = 8'hFF;
        tick(); idle(); #1;
        chk("empty_busy", 64'(dut.rs_entry_busy), 64'(0));
        chk("empty_valid", 64'(valid), 64'(1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
